// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit on the data-memory port.
package lsu_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // addr[31:28] value that selects RAM; everything else is MMIO
    localparam logic [3:0] MEM_REGION_DEF = 4'h0;

    // Well-known MMIO locations used by the test environment
    localparam logic [31:0] SIG_ADDR  = 32'hF000_0004;
    localparam logic [31:0] HALT_ADDR = 32'hCAFE_CAFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 32-bit memory word and RV32I load/store data.
// Loads: pick the lane selected by the low address bits and extend it.
// Stores: shift the store data into its lane and merge it into the read word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      ofs,
    input  logic [XLEN-1:0] rd_word,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] st_lane,
    output logic [XLEN-1:0] st_merge
);

    logic [4:0]             sh_amt;
    logic [7:0]             byte_u;
    logic [15:0]            half_u;
    logic signed [7:0]      byte_s;
    logic signed [15:0]     half_s;
    logic signed [XLEN-1:0] byte_sx;
    logic signed [XLEN-1:0] half_sx;
    logic [XLEN-1:0]        st_mask;

    assign sh_amt  = {ofs, 3'b000};
    assign byte_u  = rd_word[sh_amt +: 8];
    assign half_u  = ofs[1] ? rd_word[XLEN-1:16] : rd_word[15:0];
    assign byte_s  = byte_u;
    assign half_s  = half_u;
    assign byte_sx = XLEN'(byte_s);
    assign half_sx = XLEN'(half_s);

    // Load extraction: sign- or zero-extend the selected lane
    always_comb begin
        ld_data = '0;
        case (funct3)
            F3_LB:   ld_data = byte_sx;
            F3_LH:   ld_data = half_sx;
            F3_LW:   ld_data = rd_word;
            F3_LBU:  ld_data = XLEN'(byte_u);
            F3_LHU:  ld_data = XLEN'(half_u);
            default: ld_data = '0;
        endcase
    end

    // Store steering: position the store data in its lane and build the lane mask
    always_comb begin
        st_mask = '0;
        st_lane = '0;
        case (funct3[1:0])
            2'b00: begin
                st_mask = XLEN'(8'hFF) << sh_amt;
                st_lane = XLEN'(st_data[7:0]) << sh_amt;
            end
            2'b01: begin
                st_mask = XLEN'(16'hFFFF) << sh_amt;
                st_lane = XLEN'(st_data[15:0]) << sh_amt;
            end
            default: begin
                st_mask = '1;
                st_lane = st_data;
            end
        endcase
    end

    assign st_merge = (rd_word & ~st_mask) | (st_lane & st_mask);

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit driving a word-wide data-memory port without byte enables.
// Sub-word stores to RAM are done as read-modify-write; MMIO accesses bypass
// alignment checks and are written directly with the data in its lane.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter logic [3:0] MEM_REGION = MEM_REGION_DEF,
    parameter int         XLEN       = 32
) (
    input  logic            sysclk,
    input  logic            rst_in,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_req_we,
    input  logic [2:0]      lsu_req_funct3,
    input  logic [XLEN-1:0] lsu_req_addr,
    input  logic [XLEN-1:0] lsu_req_wdata,
    output logic            lsu_rsp_valid,
    output logic [XLEN-1:0] lsu_rsp_rdata,
    output logic            lsu_rsp_err,
    output logic [XLEN-1:0] dmem_rd_addr,
    input  logic [XLEN-1:0] dmem_rd_data,
    output logic [XLEN-1:0] dmem_wr_addr,
    output logic [XLEN-1:0] dmem_wr_data,
    output logic            dmem_wr_en
);

    lsu_state_t      state;

    // Request fields held for the duration of the operation
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdbuf;

    logic            accept;
    logic            req_ram;
    logic            req_illegal;
    logic            req_misal;
    logic            req_sw;
    logic [XLEN-1:0] req_addr_al;
    logic            ram_q;
    logic            sw_q;

    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_lane;
    logic [XLEN-1:0] st_merge;

    assign lsu_req_ready = (state == ST_IDLE);
    assign accept        = lsu_req_valid && lsu_req_ready;

    assign req_ram     = (lsu_req_addr[XLEN-1 -: 4] == MEM_REGION);
    assign req_sw      = lsu_req_we && (lsu_req_funct3 == F3_SW);
    assign req_addr_al = {lsu_req_addr[XLEN-1:2], 2'b00};

    // Stores only have SB/SH/SW; loads have no 011/110/111
    assign req_illegal = lsu_req_we ? (lsu_req_funct3 > F3_SW)
                                    : ((lsu_req_funct3 == 3'b011) || (lsu_req_funct3[2:1] == 2'b11));

    // Alignment is only enforced for RAM; MMIO sees the raw address
    always_comb begin
        req_misal = 1'b0;
        if (req_ram) begin
            case (lsu_req_funct3[1:0])
                2'b01:   req_misal = lsu_req_addr[0];
                2'b10:   req_misal = (lsu_req_addr[1:0] != 2'b00);
                default: req_misal = 1'b0;
            endcase
        end
    end

    assign ram_q = (addr_q[XLEN-1 -: 4] == MEM_REGION);
    assign sw_q  = (f3_q == F3_SW);

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3  (f3_q),
        .ofs     (addr_q[1:0]),
        .rd_word (rdbuf),
        .st_data (wdata_q),
        .ld_data (ld_data),
        .st_lane (st_lane),
        .st_merge(st_merge)
    );

    // Load data is only presented with a successful load response
    assign lsu_rsp_rdata = (lsu_rsp_valid && !we_q && !lsu_rsp_err) ? ld_data : '0;

    // RAM sub-word stores merge into the read word; SW and MMIO use the lane data
    assign dmem_wr_data = dmem_wr_en ? ((ram_q && !sw_q) ? st_merge : st_lane) : '0;

    // Request capture and read buffer; pure data, no reset needed
    always_ff @(posedge sysclk) begin
        if (accept) begin
            we_q    <= lsu_req_we;
            f3_q    <= lsu_req_funct3;
            addr_q  <= lsu_req_addr;
            wdata_q <= lsu_req_wdata;
        end
        if (state == ST_RD) begin
            rdbuf <= dmem_rd_data;
        end
    end

    // Control FSM with registered strobes and memory addresses
    always_ff @(posedge sysclk or posedge rst_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            dmem_wr_en    <= 1'b0;
            dmem_rd_addr  <= '0;
            dmem_wr_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_illegal || req_misal) begin
                            state         <= ST_RESP;
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_err   <= 1'b1;
                        end else if (!lsu_req_we) begin
                            state        <= ST_RD;
                            dmem_rd_addr <= req_addr_al;
                        end else if (req_sw || !req_ram) begin
                            state        <= ST_WR;
                            dmem_wr_en   <= 1'b1;
                            dmem_wr_addr <= req_ram ? req_addr_al : lsu_req_addr;
                        end else begin
                            state        <= ST_RD;
                            dmem_rd_addr <= req_addr_al;
                        end
                    end
                end
                ST_RD: begin
                    if (!we_q) begin
                        state         <= ST_RESP;
                        lsu_rsp_valid <= 1'b1;
                    end else begin
                        state        <= ST_WR;
                        dmem_wr_en   <= 1'b1;
                        dmem_wr_addr <= {addr_q[XLEN-1:2], 2'b00};
                    end
                end
                ST_WR: begin
                    state         <= ST_RESP;
                    dmem_wr_en    <= 1'b0;
                    lsu_rsp_valid <= 1'b1;
                end
                default: begin
                    state         <= ST_IDLE;
                    lsu_rsp_valid <= 1'b0;
                    lsu_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem with a small word memory model on the dmem port.
module tb_lsu_dmem;

    logic        sysclk = 1'b0;
    logic        rst_in = 1'b1;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_we = 1'b0;
    logic [2:0]  lsu_req_funct3 = 3'b000;
    logic [31:0] lsu_req_addr = 32'h0;
    logic [31:0] lsu_req_wdata = 32'h0;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;
    logic [31:0] dmem_rd_addr;
    logic [31:0] dmem_rd_data;
    logic [31:0] dmem_wr_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_wr_en;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_err_s = 1'b0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    logic [31:0] wr_addr_s = 32'h0;
    logic [31:0] wr_data_s = 32'h0;
    int got_rsp = 0;
    int n_wr = 0;

    logic [31:0] mem [0:255];
    bit          init_done = 1'b0;

    lsu_dmem dut (
        .sysclk        (sysclk),
        .rst_in        (rst_in),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_funct3(lsu_req_funct3),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .lsu_rsp_err   (lsu_rsp_err),
        .dmem_rd_addr  (dmem_rd_addr),
        .dmem_rd_data  (dmem_rd_data),
        .dmem_wr_addr  (dmem_wr_addr),
        .dmem_wr_data  (dmem_wr_data),
        .dmem_wr_en    (dmem_wr_en)
    );

    always #5 sysclk = ~sysclk;

    // Edge counter used to measure latencies
    always @(posedge sysclk) cyc <= cyc + 1;

    // Word memory: RAM region only, combinational read
    assign dmem_rd_data = (dmem_rd_addr[31:28] == 4'h0) ? mem[dmem_rd_addr[9:2]] : 32'h0;

    always @(posedge sysclk) begin
        if (!init_done) begin
            mem[64]   <= 32'h8899AABB;
            init_done <= 1'b1;
        end else if (dmem_wr_en && dmem_wr_addr[31:28] == 4'h0) begin
            mem[dmem_wr_addr[9:2]] <= dmem_wr_data;
        end
    end

    // Record responses and write strobes with the edge that sees them
    always @(negedge sysclk) begin
        if (lsu_rsp_valid) begin
            rsp_cnt++;
            rsp_cyc   = cyc + 1;
            rsp_data  = lsu_rsp_rdata;
            rsp_err_s = lsu_rsp_err;
        end
        if (dmem_wr_en) begin
            wr_cnt++;
            wr_cyc    = cyc + 1;
            wr_addr_s = dmem_wr_addr;
            wr_data_s = dmem_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
        int r0;
        int w0;
        @(negedge sysclk);
        lsu_req_valid  = 1'b1;
        lsu_req_we     = we;
        lsu_req_funct3 = f3;
        lsu_req_addr   = addr;
        lsu_req_wdata  = wdata;
        r0 = rsp_cnt;
        w0 = wr_cnt;
        @(posedge sysclk);
        #1;
        acc_cyc       = cyc;
        lsu_req_valid = 1'b0;
        for (int i = 0; i < 8 && rsp_cnt == r0; i++) begin
            @(negedge sysclk);
            #1;
        end
        got_rsp = (rsp_cnt != r0) ? 1 : 0;
        n_wr    = wr_cnt - w0;
        if (got_rsp == 0) chk("rsp_timeout", 32'(got_rsp), 32'd1);
    endtask

    initial begin
        int w0;
        int r0;

        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_ready",   32'(lsu_req_ready), 32'd1);
        chk("rst_rspv",    32'(lsu_rsp_valid), 32'd0);
        chk("rst_rdata",   lsu_rsp_rdata, 32'h0);
        chk("rst_err",     32'(lsu_rsp_err), 32'd0);
        chk("rst_wren",    32'(dmem_wr_en), 32'd0);
        chk("rst_wdata",   dmem_wr_data, 32'h0);
        chk("rst_rdaddr",  dmem_rd_addr, 32'h0);
        chk("rst_wraddr",  dmem_wr_addr, 32'h0);
        @(negedge sysclk);
        rst_in = 1'b0;

        // Loads from word 0x100 = 0x8899AABB
        run(1'b0, 3'b000, 32'h101, 32'h0);
        chk("lb_lat",   32'(rsp_cyc - acc_cyc), 32'd2);
        chk("lb_data",  rsp_data, 32'hFFFFFFAA);
        chk("lb_err",   32'(rsp_err_s), 32'd0);
        chk("lb_nowr",  32'(n_wr), 32'd0);
        run(1'b0, 3'b100, 32'h101, 32'h0);
        chk("lbu_data", rsp_data, 32'h000000AA);
        run(1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh_data",  rsp_data, 32'hFFFF8899);
        run(1'b0, 3'b101, 32'h102, 32'h0);
        chk("lhu_data", rsp_data, 32'h00008899);
        run(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_lat",   32'(rsp_cyc - acc_cyc), 32'd2);
        chk("lw_data",  rsp_data, 32'h8899AABB);

        // SB into RAM: read-modify-write
        run(1'b1, 3'b000, 32'h102, 32'h00000011);
        chk("sb_nwr",   32'(n_wr), 32'd1);
        chk("sb_wrlat", 32'(wr_cyc - acc_cyc), 32'd2);
        chk("sb_wradr", wr_addr_s, 32'h100);
        chk("sb_wrdat", wr_data_s, 32'h8811AABB);
        chk("sb_lat",   32'(rsp_cyc - acc_cyc), 32'd3);
        chk("sb_err",   32'(rsp_err_s), 32'd0);
        chk("sb_rdata", rsp_data, 32'h0);
        run(1'b0, 3'b010, 32'h100, 32'h0);
        chk("sb_mem",   rsp_data, 32'h8811AABB);

        // SH into RAM low half
        run(1'b1, 3'b001, 32'h100, 32'h00001234);
        chk("sh_wrdat", wr_data_s, 32'h88111234);
        chk("sh_lat",   32'(rsp_cyc - acc_cyc), 32'd3);

        // Misaligned and illegal requests
        run(1'b0, 3'b001, 32'h103, 32'h0);
        chk("lh_mis_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("lh_mis_err", 32'(rsp_err_s), 32'd1);
        chk("lh_mis_wr",  32'(n_wr), 32'd0);
        chk("lh_mis_dat", rsp_data, 32'h0);
        run(1'b1, 3'b010, 32'h102, 32'hDEADBEEF);
        chk("sw_mis_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("sw_mis_err", 32'(rsp_err_s), 32'd1);
        chk("sw_mis_wr",  32'(n_wr), 32'd0);
        run(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ld_ill_err", 32'(rsp_err_s), 32'd1);
        chk("ld_ill_lat", 32'(rsp_cyc - acc_cyc), 32'd1);

        // MMIO stores: exact address, no read
        run(1'b1, 3'b010, 32'hCAFECAFE, 32'hF0000000);
        chk("halt_wrlat", 32'(wr_cyc - acc_cyc), 32'd1);
        chk("halt_wradr", wr_addr_s, 32'hCAFECAFE);
        chk("halt_wrdat", wr_data_s, 32'hF0000000);
        chk("halt_err",   32'(rsp_err_s), 32'd0);
        chk("halt_lat",   32'(rsp_cyc - acc_cyc), 32'd2);
        run(1'b1, 3'b000, 32'hF0000005, 32'h00000041);
        chk("sig_wrdat",  wr_data_s, 32'h00004100);
        chk("sig_wradr",  wr_addr_s, 32'hF0000005);
        chk("sig_nwr",    32'(n_wr), 32'd1);
        chk("sig_noread", dmem_rd_addr, 32'h100);
        chk("sig_lat",    32'(rsp_cyc - acc_cyc), 32'd2);

        // Reset while an RMW is in its read cycle
        @(negedge sysclk);
        lsu_req_valid  = 1'b1;
        lsu_req_we     = 1'b1;
        lsu_req_funct3 = 3'b000;
        lsu_req_addr   = 32'h100;
        lsu_req_wdata  = 32'h00000055;
        w0 = wr_cnt;
        r0 = rsp_cnt;
        @(posedge sysclk);
        #1;
        lsu_req_valid = 1'b0;
        rst_in        = 1'b1;
        repeat (2) @(negedge sysclk);
        rst_in = 1'b0;
        @(negedge sysclk);
        #1;
        chk("rstmid_nowr",  32'(wr_cnt - w0), 32'd0);
        chk("rstmid_norsp", 32'(rsp_cnt - r0), 32'd0);
        chk("rstmid_ready", 32'(lsu_req_ready), 32'd1);
        run(1'b0, 3'b010, 32'h100, 32'h0);
        chk("rstmid_mem",   rsp_data, 32'h88111234);

        repeat (2) @(posedge sysclk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
